// File: rtl/prod_lockstep_checker_if.sv
// Observation bus between the Left/Right core copies and the lockstep checker.
// Signal names match the checker's historical port list.
interface prod_lockstep_checker_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    logic                     en_i;
    logic                     left_valid_i;
    logic [WIDTH-1:0]         left_obs_i;
    logic                     right_valid_i;
    logic [WIDTH-1:0]         right_obs_i;
    logic                     left_stall_o;
    logic                     right_stall_o;
    logic                     match_o;
    logic                     violation_o;
    logic [1:0]               cause_o;
    logic [$clog2(DEPTH):0]   count_o;
    logic [1:0]               side_o;

    modport master (
        output en_i, left_valid_i, left_obs_i, right_valid_i, right_obs_i,
        input  left_stall_o, right_stall_o, match_o, violation_o, cause_o, count_o, side_o
    );

    modport slave (
        input  en_i, left_valid_i, left_obs_i, right_valid_i, right_obs_i,
        output left_stall_o, right_stall_o, match_o, violation_o, cause_o, count_o, side_o
    );
endinterface

// File: rtl/prod_lockstep_checker.sv
// Relational lockstep checker: aligns Left/Right observation streams through a
// bounded skew buffer owned by whichever copy runs ahead, and flags divergence.
module prod_lockstep_checker #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int MAX_SKEW = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    prod_lockstep_checker_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(MAX_SKEW + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_COUNT  = CW'(1);
    localparam logic [TW-1:0] SKEW_LIMIT = TW'(MAX_SKEW);

    typedef enum logic [1:0] {
        SIDE_NONE  = 2'b00,
        SIDE_LEFT  = 2'b01,
        SIDE_RIGHT = 2'b10
    } side_e;

    side_e             sideQ, sideD;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PW-1:0]     rdPtrQ, wrPtrQ;
    logic [CW-1:0]     countQ, countD;
    logic [TW-1:0]     timerQ, timerD;
    logic              matchQ, matchD;
    logic              violQ, violD;
    logic [1:0]        causeQ, causeD;

    logic              leftStall, rightStall;
    logic              leftV, rightV;
    logic              protoErr, mismatch, timeout;
    logic              push, pop, doCmp;
    logic [WIDTH-1:0]  pushData, cmpA, cmpB, head;

    always_comb begin
        leftStall  = bus.en_i && (sideQ == SIDE_LEFT)  && (countQ == FULL_COUNT);
        rightStall = bus.en_i && (sideQ == SIDE_RIGHT) && (countQ == FULL_COUNT);
        // Observations offered while stalled are dropped, not buffered
        leftV    = bus.en_i && bus.left_valid_i  && !leftStall;
        rightV   = bus.en_i && bus.right_valid_i && !rightStall;
        protoErr = (bus.left_valid_i && leftStall) || (bus.right_valid_i && rightStall);
        head     = mem[rdPtrQ];

        push     = 1'b0;
        pop      = 1'b0;
        doCmp    = 1'b0;
        pushData = bus.left_obs_i;
        cmpA     = bus.left_obs_i;
        cmpB     = bus.right_obs_i;
        sideD    = sideQ;

        case (sideQ)
            SIDE_NONE: begin
                if (leftV && rightV) begin
                    doCmp = 1'b1;
                end else if (leftV) begin
                    push  = 1'b1;
                    sideD = SIDE_LEFT;
                end else if (rightV) begin
                    push     = 1'b1;
                    pushData = bus.right_obs_i;
                    sideD    = SIDE_RIGHT;
                end
            end
            SIDE_LEFT: begin
                push = leftV;
                if (rightV) begin
                    pop   = 1'b1;
                    doCmp = 1'b1;
                    cmpA  = head;
                end
            end
            SIDE_RIGHT: begin
                push     = rightV;
                pushData = bus.right_obs_i;
                if (leftV) begin
                    pop   = 1'b1;
                    doCmp = 1'b1;
                    cmpB  = head;
                end
            end
            default: sideD = SIDE_NONE;
        endcase

        if (pop && !push && (countQ == ONE_COUNT)) begin
            sideD = SIDE_NONE;
        end
        countD = countQ + CW'(push) - CW'(pop);

        if (!bus.en_i) begin
            timerD = timerQ;
        end else if (pop || (countQ == '0)) begin
            timerD = '0;
        end else if (timerQ == SKEW_LIMIT) begin
            timerD = timerQ;
        end else begin
            timerD = timerQ + TW'(1);
        end

        mismatch = doCmp && (cmpA != cmpB);
        matchD   = doCmp && (cmpA == cmpB);
        timeout  = bus.en_i && (timerD == SKEW_LIMIT);

        violD  = violQ || mismatch || protoErr || timeout;
        causeD = causeQ;
        if (!violQ) begin
            if (mismatch) begin
                causeD = 2'b01;
            end else if (protoErr) begin
                causeD = 2'b11;
            end else if (timeout) begin
                causeD = 2'b10;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sideQ  <= SIDE_NONE;
            rdPtrQ <= '0;
            wrPtrQ <= '0;
            countQ <= '0;
            timerQ <= '0;
            matchQ <= 1'b0;
            violQ  <= 1'b0;
            causeQ <= '0;
        end else begin
            sideQ  <= sideD;
            countQ <= countD;
            timerQ <= timerD;
            matchQ <= matchD;
            violQ  <= violD;
            causeQ <= causeD;
            if (push) begin
                wrPtrQ <= wrPtrQ + PW'(1);
            end
            if (pop) begin
                rdPtrQ <= rdPtrQ + PW'(1);
            end
        end
    end

    // Storage needs no reset: pointers and count define which entries are live
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wrPtrQ] <= pushData;
        end
    end

    assign bus.left_stall_o  = leftStall;
    assign bus.right_stall_o = rightStall;
    assign bus.match_o       = matchQ;
    assign bus.violation_o   = violQ;
    assign bus.cause_o       = causeQ;
    assign bus.count_o       = countQ;
    assign bus.side_o        = sideQ;
endmodule
